wide_lut_ram: RTL and testbench

Parametrised bus-attached register-file memory: next generation of the 16-bit bus LUT RAM, with user word width independent of the 16-bit bus, configurable depth and base address, and an optional user-side port. Sits in the core's daisy-chained bus between the bus receiver and transmitter. Every bus transaction passes through with one cycle of latency. Reads that hit the block's address window are answered on `rdata_o`.

---
 rtl/wide_lut_ram_pkg.sv | 28 ++
 rtl/wide_lut_ram_if.sv | 25 ++
 rtl/wide_lut_ram_bus_chunk_decode.sv | 39 +++
 rtl/wide_lut_ram.sv | 115 +++++++++++
 tb/tb_wide_lut_ram.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/wide_lut_ram_pkg.sv
// wide_lut_ram_pkg: shared bus constants and chunk/address decode helpers.
// Contents:
//   BUS_W    - width of the daisy-chained bus data/address (16)
//   chunks() - number of 16-bit bus chunks needed to carry a w-bit word
//   idx_w()  - index width for n entries (never below 1 bit)
//   split()  - window offset -> {word, chunk}
package wide_lut_ram_pkg;

    localparam int BUS_W = 16;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] chunk;
    } split_t;

    function automatic int chunks(input int w);
        return (w + BUS_W - 1) / BUS_W;
    endfunction

    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic split_t split(input logic [31:0] off, input int ch);
        return '{word: off / 32'(ch), chunk: off % 32'(ch)};
    endfunction

endpackage

// File: rtl/wide_lut_ram_if.sv
// wide_lut_ram_if: one hop of the daisy-chained 16-bit bus.
// Signals:
//   addr_i/wdata_i/rdata_i/rw_i/valid_i - transaction arriving from upstream
//   addr_o/wdata_o/rdata_o/rw_o/valid_o - transaction forwarded downstream
// Modports: master drives the *_i side and observes *_o; slave is the core.
interface wide_lut_ram_if
    import wide_lut_ram_pkg::*;
    ();

    logic [BUS_W-1:0] addr_i, wdata_i, rdata_i;
    logic             rw_i, valid_i;
    logic [BUS_W-1:0] addr_o, wdata_o, rdata_o;
    logic             rw_o, valid_o;

    modport master (
        output addr_i, wdata_i, rdata_i, rw_i, valid_i,
        input  addr_o, wdata_o, rdata_o, rw_o, valid_o
    );

    modport slave (
        input  addr_i, wdata_i, rdata_i, rw_i, valid_i,
        output addr_o, wdata_o, rdata_o, rw_o, valid_o
    );

endinterface

// File: rtl/wide_lut_ram_bus_chunk_decode.sv
// bus_chunk_decode: combinational window check and word/chunk split of a bus address.
// Ports:
//   addr  in  16      - bus address
//   valid in  1       - transaction strobe
//   hit   out 1       - valid and addr inside BASE_ADDR .. BASE_ADDR+DEPTH*CH-1
//   word  out AW      - word index inside the window
//   chunk out CW      - 16-bit chunk index inside that word (0 = LSBs)
module bus_chunk_decode
    import wide_lut_ram_pkg::*;
#(
    parameter  int BASE_ADDR = 0,
    parameter  int DEPTH     = 8,
    parameter  int CH        = 2,
    localparam int AW        = idx_w(DEPTH),
    localparam int CW        = idx_w(CH)
) (
    input  logic [BUS_W-1:0] addr,
    input  logic             valid,
    output logic             hit,
    output logic [AW-1:0]    word,
    output logic [CW-1:0]    chunk
);

    logic [31:0] off;
    split_t      s;
    logic        unused_hi;

    // Done in 32 bits so addresses below the base wrap to huge offsets and miss.
    always_comb begin
        off   = {16'd0, addr} - 32'(BASE_ADDR);
        s     = split(off, CH);
        hit   = valid && ({16'd0, addr} >= 32'(BASE_ADDR)) && (off < 32'(DEPTH * CH));
        word  = s.word[AW-1:0];
        chunk = s.chunk[CW-1:0];
    end

    assign unused_hi = ^{s.word[31:AW], s.chunk[31:CW]};

endmodule

// File: rtl/wide_lut_ram.sv
// wide_lut_ram: bus-attached register-file memory with WIDTH-bit words carried as 16-bit chunks.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   bus        - slave side of one daisy-chain hop; every transaction is forwarded after
//                one cycle, reads hitting the window get rdata_o replaced
//   user_addr  - user word index
//   user_wdata - user write data
//   user_we    - user write enable (wins over a bus commit to the same word)
//   user_rdata - registered mem[user_addr], read-before-write
module wide_lut_ram
    import wide_lut_ram_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int DEPTH     = 8,
    parameter  int BASE_ADDR = 0,
    parameter  int READ_ONLY = 0,
    parameter  int USER_PORT = 1,
    localparam int AW        = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    wide_lut_ram_if.slave     bus,
    input  logic [AW-1:0]     user_addr,
    input  logic [WIDTH-1:0]  user_wdata,
    input  logic              user_we,
    output logic [WIDTH-1:0]  user_rdata
);

    localparam int CH = chunks(WIDTH);
    localparam int CW = idx_w(CH);
    localparam int PW = CH * BUS_W;

    logic             hit;
    logic [AW-1:0]    word;
    logic [CW-1:0]    chunk;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    stage;
    logic [WIDTH-1:0] snap;
    logic [AW-1:0]    snap_word;
    logic             snap_valid;

    logic             top_chunk, rd_hit, stage_we, bus_commit, usr_we;
    logic [PW-1:0]    live_pad, rd_src, commit_pad;
    logic [BUS_W-1:0] rd_data;

    bus_chunk_decode #(
        .BASE_ADDR(BASE_ADDR),
        .DEPTH    (DEPTH),
        .CH       (CH)
    ) u_dec (
        .addr (bus.addr_i),
        .valid(bus.valid_i),
        .hit  (hit),
        .word (word),
        .chunk(chunk)
    );

    always_comb begin
        top_chunk  = chunk == CW'(CH - 1);
        rd_hit     = hit && !bus.rw_i;
        stage_we   = hit && bus.rw_i && READ_ONLY == 0 && !top_chunk;
        usr_we     = USER_PORT != 0 && user_we;
        // A user write to the same word in the same cycle overrides the bus commit.
        bus_commit = hit && bus.rw_i && READ_ONLY == 0 && top_chunk
                     && !(usr_we && user_addr == word);
        live_pad   = PW'(mem[word]);
        // Upper chunks come from the snapshot only while it still describes this word,
        // giving a coherent multi-chunk read even if the word changes in between.
        rd_src     = (chunk != '0 && snap_valid && snap_word == word) ? PW'(snap) : live_pad;
        rd_data    = rd_src[chunk*BUS_W +: BUS_W];
        commit_pad = stage;
        commit_pad[PW-1 -: BUS_W] = bus.wdata_i;
    end

    if (PW > WIDTH) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^commit_pad[PW-1:WIDTH];
    end

    // Distributed RAM: async read, no reset on contents.
    always_ff @(posedge clk) begin
        if (bus_commit) mem[word] <= commit_pad[WIDTH-1:0];
        if (usr_we) mem[user_addr] <= user_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.addr_o  <= '0;
            bus.wdata_o <= '0;
            bus.rdata_o <= '0;
            bus.rw_o    <= 1'b0;
            bus.valid_o <= 1'b0;
            user_rdata  <= '0;
            stage       <= '0;
            snap        <= '0;
            snap_word   <= '0;
            snap_valid  <= 1'b0;
        end else begin
            bus.addr_o  <= bus.addr_i;
            bus.wdata_o <= bus.wdata_i;
            bus.rw_o    <= bus.rw_i;
            bus.valid_o <= bus.valid_i;
            bus.rdata_o <= rd_hit ? rd_data : bus.rdata_i;
            user_rdata  <= USER_PORT != 0 ? mem[user_addr] : '0;
            if (stage_we) stage[chunk*BUS_W +: BUS_W] <= bus.wdata_i;
            if (rd_hit && chunk == '0) begin
                snap       <= mem[word];
                snap_word  <= word;
                snap_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wide_lut_ram.sv
// tb_wide_lut_ram: directed scoreboard bench for wide_lut_ram (WIDTH=40, DEPTH=8, BASE 0x10).
module tb_wide_lut_ram;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wide_lut_ram_if aif();
    wide_lut_ram_if bif();

    logic [2:0]  a_uaddr, b_uaddr;
    logic [39:0] a_uwd, b_uwd, a_urd, b_urd;
    logic        a_uwe, b_uwe;

    wide_lut_ram #(.WIDTH(40), .DEPTH(8), .BASE_ADDR('h10), .READ_ONLY(0), .USER_PORT(1)) dut_a (
        .clk(clk), .rst(rst), .bus(aif.slave),
        .user_addr(a_uaddr), .user_wdata(a_uwd), .user_we(a_uwe), .user_rdata(a_urd)
    );

    wide_lut_ram #(.WIDTH(40), .DEPTH(8), .BASE_ADDR('h10), .READ_ONLY(1), .USER_PORT(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bif.slave),
        .user_addr(b_uaddr), .user_wdata(b_uwd), .user_we(b_uwe), .user_rdata(b_urd)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        rw;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus(input bit b, input logic [15:0] a, input logic [15:0] w,
                       input logic rw, input logic [15:0] ri, input logic [15:0] er);
        exp_t e;
        if (b) begin
            bif.addr_i = a; bif.wdata_i = w; bif.rw_i = rw; bif.rdata_i = ri; bif.valid_i = 1'b1;
        end else begin
            aif.addr_i = a; aif.wdata_i = w; aif.rw_i = rw; aif.rdata_i = ri; aif.valid_i = 1'b1;
        end
        sb.push_back('{addr: a, wdata: w, rw: rw, rdata: er});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("valid_o@%h", a), b ? bif.valid_o : aif.valid_o, 1);
        chk($sformatf("addr_o@%h", a),  b ? bif.addr_o  : aif.addr_o,  e.addr);
        chk($sformatf("wdata_o@%h", a), b ? bif.wdata_o : aif.wdata_o, e.wdata);
        chk($sformatf("rw_o@%h", a),    b ? bif.rw_o    : aif.rw_o,    e.rw);
        chk($sformatf("rdata_o@%h", a), b ? bif.rdata_o : aif.rdata_o, e.rdata);
    endtask

    task automatic idle();
        aif.valid_i = 1'b0;
        bif.valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_valid_a", aif.valid_o, 0);
        chk("idle_valid_b", bif.valid_o, 0);
    endtask

    task automatic ucheck(input bit b, input string tag, input logic [39:0] exp);
        chk(tag, b ? b_urd : a_urd, exp);
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, "_addr_o"},  aif.addr_o,  0);
        chk({tag, "_wdata_o"}, aif.wdata_o, 0);
        chk({tag, "_rdata_o"}, aif.rdata_o, 0);
        chk({tag, "_rw_o"},    aif.rw_o,    0);
        chk({tag, "_valid_o"}, aif.valid_o, 0);
        chk({tag, "_user_rdata"}, a_urd,    0);
    endtask

    initial begin
        aif.addr_i = 16'h1234; aif.wdata_i = 16'h5678; aif.rw_i = 1'b1; aif.rdata_i = 16'hAAAA; aif.valid_i = 1'b1;
        bif.addr_i = 16'h1234; bif.wdata_i = 16'h5678; bif.rw_i = 1'b1; bif.rdata_i = 16'hAAAA; bif.valid_i = 1'b1;
        a_uaddr = 3'd2; a_uwd = '0; a_uwe = 1'b0;
        b_uaddr = 3'd0; b_uwd = '0; b_uwe = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_outputs_zero("rst0");
        rst = 1'b0;

        // Three-chunk write of word 2, then read back each chunk.
        bus(0, 'h16, 'h1111, 1, 'h0101, 'h0101);
        bus(0, 'h17, 'h2222, 1, 'h0202, 'h0202);
        bus(0, 'h18, 'h0033, 1, 'h0303, 'h0303);
        bus(0, 'h16, 'h0000, 0, 'h9999, 'h1111);
        bus(0, 'h17, 'h0000, 0, 'h9999, 'h2222);
        bus(0, 'h18, 'h0000, 0, 'h9999, 'h0033);
        idle();
        ucheck(0, "user_w2", 40'h33_2222_1111);

        // Snapshot coherence against a user write between chunks.
        bus(0, 'h16, 'h0000, 0, 'h9999, 'h1111);
        a_uwe = 1'b1; a_uwd = 40'hFF_FFFF_FFFF;
        idle();
        a_uwe = 1'b0;
        ucheck(0, "user_rbw_old", 40'h33_2222_1111);
        bus(0, 'h17, 'h0000, 0, 'h9999, 'h2222);
        ucheck(0, "user_rbw_new", 40'hFF_FFFF_FFFF);
        bus(0, 'h16, 'h0000, 0, 'h0000, 'hFFFF);
        bus(0, 'h17, 'h0000, 0, 'h0000, 'hFFFF);
        bus(0, 'h18, 'h0000, 0, 'h0000, 'h00FF);

        // Bus commit and user write to the same word: user wins.
        bus(0, 'h1F, 'hAAAA, 1, 'h0000, 'h0000);
        bus(0, 'h20, 'hBBBB, 1, 'h0000, 'h0000);
        a_uaddr = 3'd5; a_uwe = 1'b1; a_uwd = 40'hAB_CDEF_0123;
        bus(0, 'h21, 'h00CC, 1, 'h0000, 'h0000);
        a_uwe = 1'b0;
        bus(0, 'h1F, 'h0000, 0, 'h0000, 'h0123);
        bus(0, 'h20, 'h0000, 0, 'h0000, 'hCDEF);
        bus(0, 'h21, 'h0000, 0, 'h0000, 'h00AB);
        idle();
        ucheck(0, "user_w5", 40'hAB_CDEF_0123);

        // Bus commit and user write to different words: both land.
        bus(0, 'h22, 'h0001, 1, 'h0000, 'h0000);
        bus(0, 'h23, 'h0002, 1, 'h0000, 'h0000);
        a_uaddr = 3'd7; a_uwe = 1'b1; a_uwd = 40'h77_7777_7777;
        bus(0, 'h24, 'h0003, 1, 'h0000, 'h0000);
        a_uwe = 1'b0;
        bus(0, 'h22, 'h0000, 0, 'h0000, 'h0001);
        bus(0, 'h23, 'h0000, 0, 'h0000, 'h0002);
        bus(0, 'h24, 'h0000, 0, 'h0000, 'h0003);
        bus(0, 'h27, 'h0000, 0, 'h0000, 'h0077);
        idle();
        ucheck(0, "user_w7", 40'h77_7777_7777);

        // Out-of-window traffic leaves snapshot, staging and memory alone.
        bus(0, 'h1F, 'h0000, 0, 'h0000, 'h0123);
        a_uaddr = 3'd5; a_uwe = 1'b1; a_uwd = 40'h11_2222_3333;
        idle();
        a_uwe = 1'b0;
        bus(0, 'h28, 'h4444, 0, 'hBEEF, 'hBEEF);
        bus(0, 'h0F, 'h4444, 1, 'hCAFE, 'hCAFE);
        bus(0, 'h28, 'h4444, 1, 'hCAFE, 'hCAFE);
        bus(0, 'h20, 'h0000, 0, 'h0000, 'hCDEF);
        bus(0, 'h21, 'h0000, 0, 'h0000, 'h00AB);
        bus(0, 'h1E, 'h0099, 1, 'h0000, 'h0000);
        bus(0, 'h1C, 'h0000, 0, 'h0000, 'h0001);
        bus(0, 'h1D, 'h0000, 0, 'h0000, 'h0002);
        bus(0, 'h1E, 'h0000, 0, 'h0000, 'h0099);

        // Reset in the middle of a staged word.
        bus(0, 'h16, 'h5555, 1, 'h0000, 'h0000);
        aif.addr_i = 16'h1234; aif.wdata_i = 16'h5678; aif.rdata_i = 16'hAAAA;
        #2;
        rst = 1'b1;
        #1;
        reset_outputs_zero("rst_async");
        @(posedge clk);
        #1;
        reset_outputs_zero("rst_held");
        rst = 1'b0;
        bus(0, 'h18, 'h0044, 1, 'h0000, 'h0000);
        a_uaddr = 3'd2;
        idle();
        ucheck(0, "user_after_rst", 40'h44_0000_0000);
        bus(0, 'h16, 'h0000, 0, 'h0000, 'h0000);
        bus(0, 'h17, 'h0000, 0, 'h0000, 'h0000);
        bus(0, 'h18, 'h0000, 0, 'h0000, 'h0044);

        // READ_ONLY instance: bus writes are dropped.
        b_uaddr = 3'd0; b_uwe = 1'b1; b_uwd = 40'h12_3456_789A;
        idle();
        b_uwe = 1'b0;
        bus(1, 'h10, 'h5555, 1, 'h0A0A, 'h0A0A);
        bus(1, 'h11, 'h5555, 1, 'h0B0B, 'h0B0B);
        bus(1, 'h12, 'h5555, 1, 'h0C0C, 'h0C0C);
        bus(1, 'h10, 'h0000, 0, 'h9999, 'h789A);
        bus(1, 'h11, 'h0000, 0, 'h9999, 'h3456);
        bus(1, 'h12, 'h0000, 0, 'h9999, 'h0012);
        bus(1, 'h0F, 'h0000, 0, 'hD00D, 'hD00D);
        idle();
        ucheck(1, "ro_user_w0", 40'h12_3456_789A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
